// File: rtl/rs_branch_pkg.sv
// Shared types and sizes for the branch reservation station: CDB broadcast
// format, RS entry layout and the default queue depth.
package rs_branch_pkg;

    localparam int WIDTH_OP        = 4;
    localparam int WORD_SIZE_P     = 16;
    localparam int NUM_PHYS_REG    = 32;
    localparam int ROB_ENTRY       = 16;
    localparam int RS_BRANCH_DEPTH = 4;

    localparam int TAG_W = $clog2(NUM_PHYS_REG);
    localparam int ROB_W = $clog2(ROB_ENTRY);

    localparam logic [WIDTH_OP-1:0] OP_BCC = 4'h1;
    localparam logic [WIDTH_OP-1:0] OP_BL  = 4'h2;
    localparam logic [WIDTH_OP-1:0] OP_B   = 4'h3;

    typedef struct packed {
        logic                   valid;
        logic [TAG_W-1:0]       dest;
        logic [1:0]             flags;
        logic [WORD_SIZE_P-1:0] result;
    } cdb_t;

    localparam int CDB_WIDTH = $bits(cdb_t);

    typedef struct packed {
        logic                   valid;
        logic [WIDTH_OP-1:0]    opcode;
        logic [WORD_SIZE_P-1:0] pc;
        logic                   src1_rdy;
        logic [TAG_W-1:0]       src1_tag;
        logic [WORD_SIZE_P-1:0] src1_val;
        logic                   src2_rdy;
        logic [TAG_W-1:0]       src2_tag;
        logic [WORD_SIZE_P-1:0] src2_val;
        logic [ROB_W-1:0]       rob_dest;
        logic [TAG_W-1:0]       reg_dest;
    } rs_branch_entry_t;

endpackage

// File: rtl/rs_branch_cdb_snoop.sv
// cdb_snoop: combinational tag compare of one operand against every CDB port.
// On duplicate matches the lowest-numbered port supplies the value.
module cdb_snoop
    import rs_branch_pkg::*;
#(
    parameter int CDB_PORTS = 2
) (
    input  logic [CDB_PORTS*CDB_WIDTH-1:0] cdb_i,
    input  logic [TAG_W-1:0]               tag_i,
    output logic                           hit_o,
    output logic [WORD_SIZE_P-1:0]         val_o
);

    cdb_t w_port [CDB_PORTS];
    logic w_unused_flags;

    for (genvar k = 0; k < CDB_PORTS; k++) begin : g_port
        assign w_port[k] = cdb_t'(cdb_i[k*CDB_WIDTH +: CDB_WIDTH]);
    end

    // Scan from the highest port down so the lowest matching port wins.
    always_comb begin
        hit_o          = 1'b0;
        val_o          = '0;
        w_unused_flags = 1'b0;
        for (int k = CDB_PORTS - 1; k >= 0; k--) begin
            w_unused_flags = w_unused_flags ^ (^w_port[k].flags);
            if (w_port[k].valid && (w_port[k].dest == tag_i)) begin
                hit_o = 1'b1;
                val_o = w_port[k].result;
            end
        end
    end

endmodule

// File: rtl/rs_branch.sv
// Branch reservation station: age-ordered queue with CDB wakeup and oldest-ready
// issue. Optional direct issue of a ready dispatch under `RS_BRANCH_BYPASS_EN.
module rs_branch
    import rs_branch_pkg::*;
#(
    parameter int RS_DEPTH  = RS_BRANCH_DEPTH,
    parameter int CDB_PORTS = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           disp_v_i,
    output logic                           disp_ready_o,
    input  logic [WIDTH_OP-1:0]            disp_opcode_i,
    input  logic [WORD_SIZE_P-1:0]         disp_pc_i,
    input  logic                           disp_src1_rdy_i,
    input  logic                           disp_src2_rdy_i,
    input  logic [TAG_W-1:0]               disp_src1_tag_i,
    input  logic [TAG_W-1:0]               disp_src2_tag_i,
    input  logic [WORD_SIZE_P-1:0]         disp_src1_val_i,
    input  logic [WORD_SIZE_P-1:0]         disp_src2_val_i,
    input  logic [ROB_W-1:0]               disp_rob_dest_i,
    input  logic [TAG_W-1:0]               disp_reg_dest_i,
    input  logic [CDB_PORTS*CDB_WIDTH-1:0] cdb_i,
    output logic                           exe_v_o,
    output logic [WIDTH_OP-1:0]            opcode_o,
    output logic [WORD_SIZE_P-1:0]         pc_o,
    output logic [WORD_SIZE_P-1:0]         operand1_o,
    output logic [WORD_SIZE_P-1:0]         operand2_o,
    output logic [ROB_W-1:0]               rob_dest_o,
    output logic [TAG_W-1:0]               reg_dest_o
);

    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int IW = $clog2(RS_DEPTH);

    rs_branch_entry_t r_ent [RS_DEPTH];
    logic [CW-1:0]    r_count;

    logic                   r_exe_v;
    logic [WIDTH_OP-1:0]    r_opcode;
    logic [WORD_SIZE_P-1:0] r_pc, r_op1, r_op2;
    logic [ROB_W-1:0]       r_rob;
    logic [TAG_W-1:0]       r_reg;

    rs_branch_entry_t       w_upd   [RS_DEPTH];
    rs_branch_entry_t       w_shift [RS_DEPTH];
    rs_branch_entry_t       w_next  [RS_DEPTH];
    rs_branch_entry_t       w_new;
    logic                   w_h1 [RS_DEPTH];
    logic                   w_h2 [RS_DEPTH];
    logic [WORD_SIZE_P-1:0] w_v1 [RS_DEPTH];
    logic [WORD_SIZE_P-1:0] w_v2 [RS_DEPTH];
    logic                   w_dh1, w_dh2;
    logic [WORD_SIZE_P-1:0] w_dv1, w_dv2;
    logic                   w_sel_v, w_acc, w_byp, w_wr;
    logic [IW-1:0]          w_sel_idx;
    logic [CW-1:0]          w_wr_idx;

    assign disp_ready_o = (r_count != CW'(RS_DEPTH)) && !reset_i;

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_ent
        cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop1 (
            .cdb_i(cdb_i), .tag_i(r_ent[i].src1_tag), .hit_o(w_h1[i]), .val_o(w_v1[i])
        );
        cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop2 (
            .cdb_i(cdb_i), .tag_i(r_ent[i].src2_tag), .hit_o(w_h2[i]), .val_o(w_v2[i])
        );
        if (i == RS_DEPTH - 1) begin : g_top
            assign w_shift[i] = '0;
        end else begin : g_mid
            assign w_shift[i] = w_upd[i+1];
        end
    end

    cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop_d1 (
        .cdb_i(cdb_i), .tag_i(disp_src1_tag_i), .hit_o(w_dh1), .val_o(w_dv1)
    );
    cdb_snoop #(.CDB_PORTS(CDB_PORTS)) u_snoop_d2 (
        .cdb_i(cdb_i), .tag_i(disp_src2_tag_i), .hit_o(w_dh2), .val_o(w_dv2)
    );

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_upd[i] = r_ent[i];
            if (r_ent[i].valid && !r_ent[i].src1_rdy && w_h1[i]) begin
                w_upd[i].src1_rdy = 1'b1;
                w_upd[i].src1_val = w_v1[i];
            end
            if (r_ent[i].valid && !r_ent[i].src2_rdy && w_h2[i]) begin
                w_upd[i].src2_rdy = 1'b1;
                w_upd[i].src2_val = w_v2[i];
            end
        end
    end

    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.opcode   = disp_opcode_i;
        w_new.pc       = disp_pc_i;
        w_new.src1_tag = disp_src1_tag_i;
        w_new.src2_tag = disp_src2_tag_i;
        w_new.src1_rdy = disp_src1_rdy_i || w_dh1;
        w_new.src2_rdy = disp_src2_rdy_i || w_dh2;
        w_new.src1_val = disp_src1_rdy_i ? disp_src1_val_i : w_dv1;
        w_new.src2_val = disp_src2_rdy_i ? disp_src2_val_i : w_dv2;
        w_new.rob_dest = disp_rob_dest_i;
        w_new.reg_dest = disp_reg_dest_i;
    end

    // Oldest ready entry: scan downward so the lowest index is left selected.
    always_comb begin
        w_sel_v   = 1'b0;
        w_sel_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (r_ent[i].valid && r_ent[i].src1_rdy && r_ent[i].src2_rdy) begin
                w_sel_v   = 1'b1;
                w_sel_idx = IW'(i);
            end
        end
    end

    assign w_acc = disp_v_i && disp_ready_o && !flush_i;
`ifdef RS_BRANCH_BYPASS_EN
    assign w_byp = w_acc && !w_sel_v && w_new.src1_rdy && w_new.src2_rdy;
`else
    assign w_byp = 1'b0;
`endif
    assign w_wr     = w_acc && !w_byp;
    assign w_wr_idx = r_count - CW'(w_sel_v);

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_next[i] = (w_sel_v && (IW'(i) >= w_sel_idx)) ? w_shift[i] : w_upd[i];
            if (w_wr && (CW'(i) == w_wr_idx)) begin
                w_next[i] = w_new;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= '0;
            r_count  <= '0;
            r_exe_v  <= 1'b0;
            r_opcode <= '0;
            r_pc     <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_rob    <= '0;
            r_reg    <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= '0;
            r_count <= '0;
            r_exe_v <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= w_next[i];
            r_count <= r_count + CW'(w_wr) - CW'(w_sel_v);
            r_exe_v <= w_sel_v || w_byp;
            if (w_sel_v) begin
                r_opcode <= r_ent[w_sel_idx].opcode;
                r_pc     <= r_ent[w_sel_idx].pc;
                r_op1    <= r_ent[w_sel_idx].src1_val;
                r_op2    <= r_ent[w_sel_idx].src2_val;
                r_rob    <= r_ent[w_sel_idx].rob_dest;
                r_reg    <= r_ent[w_sel_idx].reg_dest;
            end else if (w_byp) begin
                r_opcode <= w_new.opcode;
                r_pc     <= w_new.pc;
                r_op1    <= w_new.src1_val;
                r_op2    <= w_new.src2_val;
                r_rob    <= w_new.rob_dest;
                r_reg    <= w_new.reg_dest;
            end
        end
    end

    assign exe_v_o    = r_exe_v;
    assign opcode_o   = r_opcode;
    assign pc_o       = r_pc;
    assign operand1_o = r_op1;
    assign operand2_o = r_op2;
    assign rob_dest_o = r_rob;
    assign reg_dest_o = r_reg;

endmodule

// File: tb/tb_rs_branch.sv
// Bench for rs_branch: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations. Honours `RS_BRANCH_BYPASS_EN.
module tb_rs_branch;
    import rs_branch_pkg::*;

    localparam int DEPTH = RS_BRANCH_DEPTH;
    localparam int PORTS = 2;
`ifdef RS_BRANCH_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset_i = 1'b1, flush_i = 1'b0, disp_v_i = 1'b0;
    logic                       disp_ready_o;
    logic [WIDTH_OP-1:0]        disp_opcode_i = '0;
    logic [WORD_SIZE_P-1:0]     disp_pc_i = '0, disp_src1_val_i = '0, disp_src2_val_i = '0;
    logic                       disp_src1_rdy_i = 1'b0, disp_src2_rdy_i = 1'b0;
    logic [TAG_W-1:0]           disp_src1_tag_i = '0, disp_src2_tag_i = '0, disp_reg_dest_i = '0;
    logic [ROB_W-1:0]           disp_rob_dest_i = '0;
    logic [PORTS*CDB_WIDTH-1:0] cdb_i;
    logic                       exe_v_o;
    logic [WIDTH_OP-1:0]        opcode_o;
    logic [WORD_SIZE_P-1:0]     pc_o, operand1_o, operand2_o;
    logic [ROB_W-1:0]           rob_dest_o;
    logic [TAG_W-1:0]           reg_dest_o;

    logic                   cv [PORTS];
    logic [TAG_W-1:0]       cd [PORTS];
    logic [WORD_SIZE_P-1:0] cr [PORTS];

    always_comb begin
        cdb_t p;
        cdb_i = '0;
        for (int k = 0; k < PORTS; k++) begin
            p        = '0;
            p.valid  = cv[k];
            p.dest   = cd[k];
            p.result = cr[k];
            cdb_i[k*CDB_WIDTH +: CDB_WIDTH] = p;
        end
    end

    rs_branch #(.RS_DEPTH(DEPTH), .CDB_PORTS(PORTS)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .disp_v_i(disp_v_i), .disp_ready_o(disp_ready_o),
        .disp_opcode_i(disp_opcode_i), .disp_pc_i(disp_pc_i),
        .disp_src1_rdy_i(disp_src1_rdy_i), .disp_src2_rdy_i(disp_src2_rdy_i),
        .disp_src1_tag_i(disp_src1_tag_i), .disp_src2_tag_i(disp_src2_tag_i),
        .disp_src1_val_i(disp_src1_val_i), .disp_src2_val_i(disp_src2_val_i),
        .disp_rob_dest_i(disp_rob_dest_i), .disp_reg_dest_i(disp_reg_dest_i),
        .cdb_i(cdb_i), .exe_v_o(exe_v_o), .opcode_o(opcode_o), .pc_o(pc_o),
        .operand1_o(operand1_o), .operand2_o(operand2_o),
        .rob_dest_o(rob_dest_o), .reg_dest_o(reg_dest_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain age-ordered list of waiting ops.
    typedef struct {
        logic [WIDTH_OP-1:0]    op;
        logic [WORD_SIZE_P-1:0] pc;
        logic                   r1, r2;
        logic [TAG_W-1:0]       t1, t2;
        logic [WORD_SIZE_P-1:0] v1, v2;
        logic [ROB_W-1:0]       rob;
        logic [TAG_W-1:0]       rd;
    } m_ent_t;

    m_ent_t                 m_q[$];
    bit                     m_live = 1'b0;
    logic                   e_exe_v = 1'b0;
    logic [WIDTH_OP-1:0]    e_op = '0;
    logic [WORD_SIZE_P-1:0] e_pc = '0, e_o1 = '0, e_o2 = '0;
    logic [ROB_W-1:0]       e_rob = '0;
    logic [TAG_W-1:0]       e_rd = '0;

    function automatic m_ent_t wake(input m_ent_t e);
        m_ent_t r = e;
        for (int k = 0; k < PORTS; k++) begin
            if (!r.r1 && cv[k] && cd[k] == r.t1) begin r.r1 = 1'b1; r.v1 = cr[k]; end
            if (!r.r2 && cv[k] && cd[k] == r.t2) begin r.r2 = 1'b1; r.v2 = cr[k]; end
        end
        return r;
    endfunction

    task automatic load_exp(input m_ent_t e);
        e_exe_v = 1'b1;
        e_op = e.op; e_pc = e.pc; e_o1 = e.v1; e_o2 = e.v2; e_rob = e.rob; e_rd = e.rd;
    endtask

    always @(posedge clk) begin : model
        int     sel;
        bit     acc;
        m_ent_t ne;
        m_live = 1'b1;
        if (reset_i) begin
            m_q.delete();
            e_exe_v = 1'b0; e_op = '0; e_pc = '0; e_o1 = '0; e_o2 = '0; e_rob = '0; e_rd = '0;
        end else if (flush_i) begin
            m_q.delete();
            e_exe_v = 1'b0;
        end else begin
            acc = disp_v_i && (m_q.size() != DEPTH);
            ne.op = disp_opcode_i; ne.pc = disp_pc_i;
            ne.r1 = disp_src1_rdy_i; ne.t1 = disp_src1_tag_i; ne.v1 = disp_src1_val_i;
            ne.r2 = disp_src2_rdy_i; ne.t2 = disp_src2_tag_i; ne.v2 = disp_src2_val_i;
            ne.rob = disp_rob_dest_i; ne.rd = disp_reg_dest_i;
            ne = wake(ne);
            sel = -1;
            for (int i = m_q.size() - 1; i >= 0; i--)
                if (m_q[i].r1 && m_q[i].r2) sel = i;
            if (sel >= 0) begin
                load_exp(m_q[sel]);
                m_q.delete(sel);
            end else if (BYP && acc && ne.r1 && ne.r2) begin
                load_exp(ne);
                acc = 1'b0;
            end else begin
                e_exe_v = 1'b0;
            end
            foreach (m_q[i]) m_q[i] = wake(m_q[i]);
            if (acc) m_q.push_back(ne);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("disp_ready", {31'd0, disp_ready_o}, {31'd0, (m_q.size() != DEPTH) && !reset_i});
            chk("exe_v", {31'd0, exe_v_o}, {31'd0, e_exe_v});
            chk("opcode", 32'(opcode_o), 32'(e_op));
            chk("pc", 32'(pc_o), 32'(e_pc));
            chk("operand1", 32'(operand1_o), 32'(e_o1));
            chk("operand2", 32'(operand2_o), 32'(e_o2));
            chk("rob_dest", 32'(rob_dest_o), 32'(e_rob));
            chk("reg_dest", 32'(reg_dest_o), 32'(e_rd));
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_v_i = 1'b0;
        flush_i  = 1'b0;
        for (int k = 0; k < PORTS; k++) begin cv[k] = 1'b0; cd[k] = '0; cr[k] = '0; end
    endtask

    task automatic disp(input logic [WIDTH_OP-1:0] op, input logic [WORD_SIZE_P-1:0] pc,
                        input logic r1, input logic [TAG_W-1:0] t1, input logic [WORD_SIZE_P-1:0] v1,
                        input logic r2, input logic [TAG_W-1:0] t2, input logic [WORD_SIZE_P-1:0] v2,
                        input logic [ROB_W-1:0] rob, input logic [TAG_W-1:0] rd);
        disp_v_i = 1'b1; disp_opcode_i = op; disp_pc_i = pc;
        disp_src1_rdy_i = r1; disp_src1_tag_i = t1; disp_src1_val_i = v1;
        disp_src2_rdy_i = r2; disp_src2_tag_i = t2; disp_src2_val_i = v2;
        disp_rob_dest_i = rob; disp_reg_dest_i = rd;
    endtask

    task automatic bcast(input int k, input logic [TAG_W-1:0] dest, input logic [WORD_SIZE_P-1:0] res);
        cv[k] = 1'b1; cd[k] = dest; cr[k] = res;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        ticks(3);
        @(negedge clk);
        chk("ready_in_reset", {31'd0, disp_ready_o}, 32'd0);
        chk("pc_after_reset", 32'(pc_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // Fully ready BL straight through.
        disp(OP_BL, 16'h0010, 1'b1, 5'd0, 16'h1111, 1'b1, 5'd0, 16'h2222, 4'd0, 5'd1);
        tick();
        idle();
        ticks(LAT - 1);
        @(negedge clk);
        chk("bl_exe_v", {31'd0, exe_v_o}, 32'd1);
        chk("bl_pc", 32'(pc_o), 32'h0010);
        chk("bl_opcode", 32'(opcode_o), 32'(OP_BL));
        ticks(2);

        // BCC waiting on tag 5, woken by port 1.
        disp(OP_BCC, 16'h0020, 1'b1, 5'd0, 16'h0100, 1'b0, 5'd5, 16'h0000, 4'd1, 5'd2);
        tick();
        idle();
        tick();
        bcast(1, 5'd5, 16'h0004);
        tick();
        idle();
        @(negedge clk);
        chk("bcc_wait_exe_v", {31'd0, exe_v_o}, 32'd0);
        tick();
        @(negedge clk);
        chk("bcc_exe_v", {31'd0, exe_v_o}, 32'd1);
        chk("bcc_operand2", 32'(operand2_o), 32'h0004);
        chk("bcc_rob", 32'(rob_dest_o), 32'd1);
        ticks(1);

        // Fill the queue with four waiting ops, then try a fifth.
        for (int j = 0; j < 4; j++) begin
            disp(OP_BCC, 16'(16'h0100 + 4 * j), 1'b0, 5'(10 + j), 16'h0, 1'b1, 5'd0, 16'(j), 4'(2 + j), 5'(j));
            tick();
        end
        idle();
        @(negedge clk);
        chk("full_ready", {31'd0, disp_ready_o}, 32'd0);
        disp(OP_B, 16'h0300, 1'b1, 5'd0, 16'h0, 1'b1, 5'd0, 16'h0, 4'd9, 5'd9);
        tick();
        idle();
        bcast(0, 5'd12, 16'h00C0);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("slot2_exe_v", {31'd0, exe_v_o}, 32'd1);
        chk("slot2_rob", 32'(rob_dest_o), 32'd4);
        chk("slot2_op1", 32'(operand1_o), 32'h00C0);
        chk("after_issue_ready", {31'd0, disp_ready_o}, 32'd1);

        // Four entries again; wake oldest and youngest together.
        disp(OP_BCC, 16'h0400, 1'b0, 5'd14, 16'h0, 1'b1, 5'd0, 16'h0, 4'd6, 5'd6);
        tick();
        idle();
        bcast(0, 5'd10, 16'h0A0A);
        bcast(1, 5'd14, 16'h0E0E);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("age_first_rob", 32'(rob_dest_o), 32'd2);
        tick();
        @(negedge clk);
        chk("age_second_rob", 32'(rob_dest_o), 32'd6);
        chk("age_second_op1", 32'(operand1_o), 32'h0E0E);

        // Duplicate match on both ports: port 0 supplies the value.
        disp(OP_BCC, 16'h0500, 1'b0, 5'd3, 16'h0, 1'b1, 5'd0, 16'h5, 4'd7, 5'd7);
        tick();
        idle();
        bcast(0, 5'd3, 16'hAAAA);
        bcast(1, 5'd3, 16'hBBBB);
        tick();
        idle();
        tick();
        @(negedge clk);
        chk("dup_rob", 32'(rob_dest_o), 32'd7);
        chk("dup_op1", 32'(operand1_o), 32'hAAAA);

        // Producer broadcasts in the dispatch cycle.
        disp(OP_BCC, 16'h0600, 1'b0, 5'd7, 16'h0, 1'b1, 5'd0, 16'h6, 4'd8, 5'd8);
        bcast(0, 5'd7, 16'h0077);
        tick();
        idle();
        ticks(LAT - 1);
        @(negedge clk);
        chk("samecyc_exe_v", {31'd0, exe_v_o}, 32'd1);
        chk("samecyc_rob", 32'(rob_dest_o), 32'd8);
        chk("samecyc_op1", 32'(operand1_o), 32'h0077);

        // Flush with three waiting entries and a simultaneous ready dispatch.
        disp(OP_BCC, 16'h0700, 1'b0, 5'd15, 16'h0, 1'b1, 5'd0, 16'h0, 4'd10, 5'd10);
        tick();
        disp(OP_B, 16'h0800, 1'b1, 5'd0, 16'h0, 1'b1, 5'd0, 16'h0, 4'd11, 5'd11);
        flush_i = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk("flush_exe_v", {31'd0, exe_v_o}, 32'd0);
        chk("flush_ready", {31'd0, disp_ready_o}, 32'd1);
        bcast(0, 5'd11, 16'h1);
        bcast(1, 5'd13, 16'h2);
        tick();
        idle();
        bcast(0, 5'd15, 16'h3);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("post_flush_quiet", {31'd0, exe_v_o}, 32'd0);
        end

        // Back-to-back ready dispatches.
        for (int j = 0; j < 6; j++) begin
            disp(OP_B, 16'(16'h0900 + 4 * j), 1'b1, 5'd0, 16'(j), 1'b1, 5'd0, 16'(2 * j), 4'(j), 5'(j));
            tick();
        end
        idle();
        ticks(3);

        // Reset while holding entries discards them.
        disp(OP_BCC, 16'h0A00, 1'b0, 5'd20, 16'h0, 1'b1, 5'd0, 16'h0, 4'd12, 5'd12);
        tick();
        disp(OP_BCC, 16'h0A04, 1'b0, 5'd21, 16'h0, 1'b1, 5'd0, 16'h0, 4'd13, 5'd13);
        tick();
        idle();
        reset_i = 1'b1;
        tick();
        @(negedge clk);
        chk("midreset_ready", {31'd0, disp_ready_o}, 32'd0);
        chk("midreset_pc", 32'(pc_o), 32'd0);
        reset_i = 1'b0;
        bcast(0, 5'd20, 16'h1);
        bcast(1, 5'd21, 16'h2);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            chk("midreset_quiet", {31'd0, exe_v_o}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
